// File: rtl/trim_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module   : trim_sweep_gen
//  Purpose  : Serial trim-word driver with single-shot load or code sweep and
//             a settle + sample handshake per applied code.
//  Revision : 1.0
// ============================================================================
module trim_sweep_gen #(
    parameter int CODE_W       = 12,
    parameter int CLK_DIV      = 25,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int CODE_FIRST   = 0,
    parameter int CODE_LAST    = 4095,
    parameter int CODE_STEP    = 1,
    parameter int SETTLE_TICKS = 3
) (
    input  logic              CLK50,
    input  logic              RST_N,
    input  logic              START,
    input  logic              MODE,
    input  logic [CODE_W-1:0] CODE_IN,
    input  logic              ABORT,
    input  logic              SAMPLE_ACK,
    output logic              SCLK,
    output logic              DOUT,
    output logic              LATCH,
    output logic [CODE_W-1:0] TRIMCODE,
    output logic              SAMPLE_REQ,
    output logic              BUSY,
    output logic              DONE
);

    localparam int c_PRE_W = $clog2(CLK_DIV);
    localparam int c_BIT_W = $clog2(CODE_W + 1);
    localparam int c_SET_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BITS     = c_BIT_W'(CODE_W);
    localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_TICKS - 1);
    localparam logic [CODE_W-1:0]  c_FIRST    = CODE_W'(CODE_FIRST);
    localparam logic [CODE_W:0]    c_LAST     = (CODE_W + 1)'(CODE_LAST);
    localparam logic [CODE_W:0]    c_STEP     = (CODE_W + 1)'(CODE_STEP);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT    = 3'd2,
        S_LATCH    = 3'd3,
        S_SETTLE   = 3'd4,
        S_WAIT_ACK = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PRE_W-1:0]  r_presc;
    logic                r_mode;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   r_shreg;
    logic [c_BIT_W-1:0]  r_bitcnt;
    logic                r_phase;
    logic [c_SET_W-1:0]  r_settle;
    logic                r_sclk;
    logic                r_dout;
    logic                r_latch;
    logic [CODE_W-1:0]   r_trim;
    logic                r_req;

    logic                w_tick;
    logic                w_frame_end;
    logic                w_settle_end;
    logic [CODE_W:0]     w_code_sum;
    logic                w_last_code;
    logic                w_out_bit;
    logic [CODE_W-1:0]   w_shreg_nxt;

    assign w_tick       = (r_presc == c_PRE_LAST);
    assign w_frame_end  = (r_bitcnt == c_BITS);
    assign w_settle_end = (r_settle == c_SET_LAST);
    // Extra bit keeps the end-of-sweep test honest when the next code would wrap
    assign w_code_sum   = {1'b0, r_code} + c_STEP;
    assign w_last_code  = r_mode || (w_code_sum > c_LAST);

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_out_bit   = r_shreg[CODE_W-1];
            assign w_shreg_nxt = {r_shreg[CODE_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit   = r_shreg[0];
            assign w_shreg_nxt = {1'b0, r_shreg[CODE_W-1:1]};
        end
    endgenerate

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ABORT) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (START) w_state_nxt = S_LOAD;
                S_LOAD:     w_state_nxt = S_SHIFT;
                S_SHIFT:    if (w_tick && !r_phase && w_frame_end) w_state_nxt = S_LATCH;
                S_LATCH:    if (w_tick) w_state_nxt = S_SETTLE;
                S_SETTLE:   if (w_tick && w_settle_end) w_state_nxt = S_WAIT_ACK;
                S_WAIT_ACK: if (SAMPLE_ACK) w_state_nxt = w_last_code ? S_DONE : S_LOAD;
                S_DONE:     w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            r_presc  <= '0;
            r_mode   <= 1'b0;
            r_code   <= '0;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_phase  <= 1'b0;
            r_settle <= '0;
            r_sclk   <= 1'b0;
            r_dout   <= 1'b0;
            r_latch  <= 1'b0;
            r_trim   <= '0;
            r_req    <= 1'b0;
        end else begin
            r_presc <= (r_state == S_IDLE || w_tick) ? '0 : r_presc + 1'b1;
            if (ABORT) begin
                r_sclk  <= 1'b0;
                r_latch <= 1'b0;
                r_req   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (START) begin
                            r_mode <= MODE;
                            r_code <= MODE ? CODE_IN : c_FIRST;
                        end
                    end
                    S_LOAD: begin
                        r_shreg  <= r_code;
                        r_bitcnt <= '0;
                        r_phase  <= 1'b0;
                    end
                    S_SHIFT: begin
                        if (w_tick) begin
                            if (r_phase) begin
                                r_sclk   <= 1'b1;
                                r_bitcnt <= r_bitcnt + 1'b1;
                                r_phase  <= 1'b0;
                            end else if (w_frame_end) begin
                                r_sclk  <= 1'b0;
                                r_latch <= 1'b1;
                                r_trim  <= r_code;
                            end else begin
                                r_sclk  <= 1'b0;
                                r_dout  <= w_out_bit;
                                r_shreg <= w_shreg_nxt;
                                r_phase <= 1'b1;
                            end
                        end
                    end
                    S_LATCH: begin
                        if (w_tick) begin
                            r_latch  <= 1'b0;
                            r_settle <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (w_tick) begin
                            if (w_settle_end) r_req <= 1'b1;
                            else              r_settle <= r_settle + 1'b1;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (SAMPLE_ACK) begin
                            r_req <= 1'b0;
                            if (!w_last_code) r_code <= w_code_sum[CODE_W-1:0];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign SCLK       = r_sclk;
    assign DOUT       = r_dout;
    assign LATCH      = r_latch;
    assign TRIMCODE   = r_trim;
    assign SAMPLE_REQ = r_req;
    assign BUSY       = (r_state != S_IDLE);
    assign DONE       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_trim_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trim_sweep_gen
//  Purpose  : Self-checking bench for trim_sweep_gen, two parameterisations.
//  Revision : 1.0
// ============================================================================
module tb_trim_sweep_gen;

    logic       CLK50 = 1'b0;
    logic       rst_n;
    logic [1:0] start, mode, abort, ack;
    logic [3:0] code_in0, code_in1;
    wire  [1:0] sclk, dout, latch, req, busy, done;
    wire  [3:0] trim0, trim1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 CLK50 = ~CLK50;
    always @(posedge CLK50) cyc <= cyc + 1;

    trim_sweep_gen #(
        .CODE_W(4), .CLK_DIV(2), .MSB_FIRST(1'b1), .CODE_FIRST(2),
        .CODE_LAST(7), .CODE_STEP(2), .SETTLE_TICKS(3)
    ) u_dut0 (
        .CLK50(CLK50), .RST_N(rst_n), .START(start[0]), .MODE(mode[0]),
        .CODE_IN(code_in0), .ABORT(abort[0]), .SAMPLE_ACK(ack[0]),
        .SCLK(sclk[0]), .DOUT(dout[0]), .LATCH(latch[0]), .TRIMCODE(trim0),
        .SAMPLE_REQ(req[0]), .BUSY(busy[0]), .DONE(done[0])
    );

    trim_sweep_gen #(
        .CODE_W(4), .CLK_DIV(3), .MSB_FIRST(1'b0), .CODE_FIRST(14),
        .CODE_LAST(15), .CODE_STEP(1), .SETTLE_TICKS(2)
    ) u_dut1 (
        .CLK50(CLK50), .RST_N(rst_n), .START(start[1]), .MODE(mode[1]),
        .CODE_IN(code_in1), .ABORT(abort[1]), .SAMPLE_ACK(ack[1]),
        .SCLK(sclk[1]), .DOUT(dout[1]), .LATCH(latch[1]), .TRIMCODE(trim1),
        .SAMPLE_REQ(req[1]), .BUSY(busy[1]), .DONE(done[1])
    );

    // Reference parameters of the two instances
    function automatic int div_of(input int u);    return (u == 0) ? 2 : 3;   endfunction
    function automatic int settle_of(input int u); return (u == 0) ? 3 : 2;   endfunction
    function automatic bit msb_of(input int u);    return (u == 0);           endfunction
    function automatic int first_of(input int u);  return (u == 0) ? 2 : 14;  endfunction
    function automatic int last_of(input int u);   return (u == 0) ? 7 : 15;  endfunction
    function automatic int step_of(input int u);   return (u == 0) ? 2 : 1;   endfunction

    function automatic logic [3:0] trim_of(input int u);
        return (u == 0) ? trim0 : trim1;
    endfunction

    // Bits seen at SCLK rises, oldest in bit 3
    function automatic logic [3:0] exp_bits(input int u, input logic [3:0] c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[3-i] = msb_of(u) ? c[3-i] : c[i];
        return r;
    endfunction

    // Event monitor
    logic [1:0]  sclk_p = '0, latch_p = '0, req_p = '0;
    int          rise_cnt[2];
    logic [31:0] rise_bits[2];
    int          latch_cnt[2], latch_w[2], latch_start[2], latch_fall[2];
    int          settle_gap[2], done_cnt[2];
    logic [3:0]  trim_hist[2][32];

    always @(negedge CLK50) begin
        for (int u = 0; u < 2; u++) begin
            if (sclk[u] && !sclk_p[u]) begin
                rise_cnt[u]  <= rise_cnt[u] + 1;
                rise_bits[u] <= {rise_bits[u][30:0], dout[u]};
            end
            if (latch[u] && !latch_p[u]) latch_start[u] <= cyc;
            if (!latch[u] && latch_p[u]) begin
                latch_w[u]    <= cyc - latch_start[u];
                latch_fall[u] <= cyc;
                if (latch_cnt[u] < 32) trim_hist[u][latch_cnt[u]] <= trim_of(u);
                latch_cnt[u]  <= latch_cnt[u] + 1;
            end
            if (req[u] && !req_p[u]) settle_gap[u] <= cyc - latch_fall[u];
            if (done[u]) done_cnt[u] <= done_cnt[u] + 1;
        end
        sclk_p  <= sclk;
        latch_p <= latch;
        req_p   <= req;
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_code(input int u, input logic [3:0] c);
        if (u == 0) code_in0 = c;
        else        code_in1 = c;
    endtask

    task automatic wait_req(input int u, input string tag);
        for (int i = 0; i < 2000 && !req[u]; i++) @(negedge CLK50);
        check(tag, req[u], 1);
    endtask

    task automatic do_ack(input int u, input int dly);
        repeat (dly) @(negedge CLK50);
        ack[u] = 1'b1;
        @(negedge CLK50);
        ack[u] = 1'b0;
        check("ack_req_fall", req[u], 0);
    endtask

    task automatic single_shot(input int u, input logic [3:0] code, input bit poke);
        int r0, l0, d0;
        r0 = rise_cnt[u]; l0 = latch_cnt[u]; d0 = done_cnt[u];
        set_code(u, code); mode[u] = 1'b1; start[u] = 1'b1;
        @(negedge CLK50);
        start[u] = 1'b0;
        if (poke) begin
            repeat (3) @(negedge CLK50);
            set_code(u, ~code); mode[u] = 1'b0; start[u] = 1'b1;
            @(negedge CLK50);
            start[u] = 1'b0; mode[u] = 1'b1;
        end
        wait_req(u, "ss_req");
        @(negedge CLK50);
        check("ss_rises", rise_cnt[u] - r0, 4);
        check("ss_bits", rise_bits[u][3:0], exp_bits(u, code));
        check("ss_latches", latch_cnt[u] - l0, 1);
        check("ss_latch_w", latch_w[u], div_of(u));
        check("ss_trim", trim_of(u), code);
        check("ss_settle", settle_gap[u], settle_of(u) * div_of(u));
        do_ack(u, 32'($urandom_range(0, 4)));
        check("ss_done_pulse", done[u], 1);
        @(negedge CLK50);
        check("ss_busy_after", busy[u], 0);
        check("ss_done_low", done[u], 0);
        check("ss_done_cnt", done_cnt[u] - d0, 1);
    endtask

    task automatic sweep(input int u);
        int q[$];
        int l0, d0;
        for (int c = first_of(u); c <= last_of(u); c += step_of(u)) q.push_back(c);
        l0 = latch_cnt[u]; d0 = done_cnt[u];
        set_code(u, 4'h0); mode[u] = 1'b0; start[u] = 1'b1;
        @(negedge CLK50);
        start[u] = 1'b0;
        foreach (q[k]) begin
            wait_req(u, "sw_req");
            @(negedge CLK50);
            check("sw_trim", trim_of(u), q[k]);
            check("sw_bits", rise_bits[u][3:0], exp_bits(u, q[k][3:0]));
            do_ack(u, 4);
            check("sw_done", done[u], (k == q.size() - 1) ? 1 : 0);
        end
        @(negedge CLK50);
        check("sw_latches", latch_cnt[u] - l0, q.size());
        if (latch_cnt[u] >= 1 && latch_cnt[u] <= 32)
            check("sw_last_hist", trim_hist[u][latch_cnt[u]-1], q[q.size()-1]);
        check("sw_done_cnt", done_cnt[u] - d0, 1);
        check("sw_busy_after", busy[u], 0);
    endtask

    initial begin
        logic [3:0] rc;
        int r0, l0, d0;
        rst_n = 1'b0; start = '0; mode = '0; abort = '0; ack = '0;
        code_in0 = '0; code_in1 = '0;
        repeat (3) @(negedge CLK50);
        check("rst_outs0", {sclk[0], dout[0], latch[0], req[0], busy[0], done[0]}, 0);
        check("rst_outs1", {sclk[1], dout[1], latch[1], req[1], busy[1], done[1]}, 0);
        check("rst_trim0", trim0, 0);
        check("rst_trim1", trim1, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge CLK50);

        single_shot(0, 4'hA, 1'b0);
        single_shot(1, 4'hA, 1'b0);
        for (int k = 0; k < 6; k++) begin
            rc = 4'($urandom_range(0, 15));
            single_shot(k % 2, rc, 1'b0);
        end

        sweep(0);
        sweep(1);

        // Abort during the second frame of a sweep
        l0 = latch_cnt[0]; d0 = done_cnt[0];
        mode[0] = 1'b0; start[0] = 1'b1;
        @(negedge CLK50);
        start[0] = 1'b0;
        wait_req(0, "ab_req1");
        do_ack(0, 1);
        r0 = rise_cnt[0];
        for (int i = 0; i < 500 && (rise_cnt[0] - r0) < 2; i++) @(negedge CLK50);
        check("ab_in_frame2", busy[0], 1);
        abort[0] = 1'b1;
        @(negedge CLK50);
        abort[0] = 1'b0;
        check("ab_busy", busy[0], 0);
        check("ab_sclk", sclk[0], 0);
        check("ab_latch", latch[0], 0);
        check("ab_req", req[0], 0);
        check("ab_trim", trim0, first_of(0));
        repeat (20) @(negedge CLK50);
        check("ab_no_done", done_cnt[0] - d0, 0);
        check("ab_latches", latch_cnt[0] - l0, 1);

        // Abort and acknowledge together
        d0 = done_cnt[0];
        mode[0] = 1'b0; start[0] = 1'b1;
        @(negedge CLK50);
        start[0] = 1'b0;
        wait_req(0, "aa_req");
        abort[0] = 1'b1; ack[0] = 1'b1;
        @(negedge CLK50);
        abort[0] = 1'b0; ack[0] = 1'b0;
        check("aa_busy", busy[0], 0);
        check("aa_done", done[0], 0);
        check("aa_req", req[0], 0);
        repeat (10) @(negedge CLK50);
        check("aa_no_done", done_cnt[0] - d0, 0);
        check("aa_trim", trim0, first_of(0));

        // Asynchronous reset in the middle of a frame
        l0 = latch_cnt[0];
        set_code(0, 4'hD); mode[0] = 1'b1; start[0] = 1'b1;
        @(negedge CLK50);
        start[0] = 1'b0;
        r0 = rise_cnt[0];
        for (int i = 0; i < 500 && (rise_cnt[0] - r0) < 1; i++) @(negedge CLK50);
        check("rm_in_shift", busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("rm_outs", {sclk[0], dout[0], latch[0], req[0], busy[0], done[0]}, 0);
        check("rm_trim", trim0, 0);
        @(negedge CLK50);
        rst_n = 1'b1;
        @(negedge CLK50);
        check("rm_no_latch", latch_cnt[0] - l0, 0);

        // Fresh run with a START pulse while busy
        rc = 4'($urandom_range(1, 15));
        single_shot(0, rc, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/trim_sweep_gen.md
Name: trim_sweep_gen

Overview:
Parametrised successor to the bandgap trim shifter. It drives a CODE_W-bit trim word into the on-chip trim shift register over a 3-wire serial link (SCLK/DOUT/LATCH). It supports single-shot load of an external code or an automatic sweep from CODE_FIRST to CODE_LAST. Each applied code gets a settle interval, then a SAMPLE_REQ/SAMPLE_ACK handshake with the measurement logic before the next code is sent. All logic runs on CLK50 using a prescaler-derived tick; no derived or gated clocks.

Parameters:
CODE_W, 12, trim word width (2..16)
CLK_DIV, 25, CLK50 cycles per tick (>=2); one tick = one serial half-period
MSB_FIRST, 1, 1: shift bit CODE_W-1 first; 0: bit 0 first
CODE_FIRST, 0, first sweep code
CODE_LAST, 4095, last sweep code; CODE_FIRST <= CODE_LAST required
CODE_STEP, 1, sweep increment (>=1)
SETTLE_TICKS, 3, ticks between LATCH fall and SAMPLE_REQ rise (>=1)

Ports:
CLK50  in  1  system clock
RST_N  in  1  reset, asynchronous, active-low
START  in  1  begin operation; sampled in IDLE only
MODE  in  1  0 = sweep, 1 = single-shot; captured with START
CODE_IN  in  CODE_W  code for single-shot; captured with START
ABORT  in  1  terminate any operation
SAMPLE_ACK  in  1  measurement done for current code
SCLK  out  1  serial clock to trim register (data valid on rising edge)
DOUT  out  1  serial data
LATCH  out  1  parallel-load strobe to trim register, high for one tick
TRIMCODE  out  CODE_W  code most recently latched
SAMPLE_REQ  out  1  current code applied and settled
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-CLK50-cycle pulse on completion

Behaviour:
- Reset (RST_N low, async): state IDLE; prescaler = 0. SCLK, DOUT, LATCH, SAMPLE_REQ, BUSY and DONE = 0. TRIMCODE = 0.
- Tick: prescaler counts 0..CLK_DIV-1 and wraps. Tick is asserted when the count equals CLK_DIV-1. Prescaler is cleared on leaving IDLE.
- IDLE: on START=1, capture MODE. Set code_reg = CODE_IN if MODE=1, else CODE_FIRST. Go to LOAD on the next CLK50 edge.
- LOAD (1 CLK50 cycle): shreg <= code_reg, bitcnt <= 0, phase <= 0. Go to SHIFT.
- SHIFT, on each tick:
  - phase 0: SCLK <= 0; DOUT <= shreg bit per MSB_FIRST; shreg shifts.
  - phase 1: SCLK <= 1; bitcnt++.
  - After the CODE_W-th rising edge, the next tick drives SCLK <= 0 and moves to LATCH. A frame is exactly 2*CODE_W ticks of SCLK activity, with CODE_W rising edges.
- LATCH: LATCH = 1 for exactly one tick. TRIMCODE <= code_reg when LATCH rises. On the next tick, LATCH = 0 and go to SETTLE.
- SETTLE: count SETTLE_TICKS ticks, then go to WAIT_ACK with SAMPLE_REQ = 1.
- WAIT_ACK: SAMPLE_REQ held high until SAMPLE_ACK = 1 is seen on a CLK50 edge; SAMPLE_REQ falls on that same edge.
  - If MODE = 1, or code_reg + CODE_STEP > CODE_LAST (compared in CODE_W+1 bits, no wrap): go to DONE.
  - Otherwise: code_reg += CODE_STEP, go to LOAD.
  - SAMPLE_ACK outside WAIT_ACK is ignored.
- DONE: DONE = 1 for one CLK50 cycle, BUSY = 0 on return to IDLE; TRIMCODE holds its value.
- ABORT = 1 in any non-IDLE state: IDLE on the next edge. SCLK, LATCH and SAMPLE_REQ forced to 0. No DONE pulse. TRIMCODE retains its last latched value.
- ABORT has priority over SAMPLE_ACK and START in the same cycle.
- START while BUSY is ignored. DOUT holds its last value when idle.
- RST_N asserted mid-frame: all outputs return to reset values immediately, with no partial latch.

Test Plan:
1. CODE_W=4, CLK_DIV=2, MSB_FIRST=1, MODE=1, CODE_IN=4'b1010, START -> 4 SCLK rising edges with DOUT=1,0,1,0 at each rise; LATCH one tick wide; TRIMCODE=4'hA; SAMPLE_REQ after 3 ticks; ACK -> DONE pulse, BUSY=0.
2. Same as 1 with MSB_FIRST=0 -> DOUT sequence at rises 0,1,0,1.
3. Sweep with CODE_FIRST=2, CODE_LAST=7, CODE_STEP=2, ACK returned 5 cycles after each REQ -> TRIMCODE steps 2, 4, 6; exactly 3 LATCH pulses; DONE after the third ACK (8 > 7, no wrap).
4. Sweep with CODE_W=4, CODE_FIRST=14, CODE_LAST=15, CODE_STEP=1 -> codes 14, 15, then DONE; no wrap to 0.
5. ABORT during the 2nd frame of a sweep -> IDLE next cycle; SCLK/LATCH/SAMPLE_REQ = 0; no DONE; TRIMCODE equals the 1st code. ABORT together with SAMPLE_ACK -> abort wins.
6. RST_N pulled low mid-SHIFT, then START pulsed while BUSY in a fresh run -> outputs zero immediately, TRIMCODE=0; the START while BUSY has no effect.
